// File: rtl/nibble_packer_if.sv
// Nibble-in / byte-out handshake bundle for nibble_packer.
//   in_nib/in_valid/in_first/in_ready : nibble stream toward the packer
//   out_data/out_valid/out_ready/out_swap : packed byte stream toward the swapper
// master = upstream/consumer side (testbench), slave = packer side.
interface nibble_packer_if;
  logic [3:0] in_nib;
  logic       in_valid;
  logic       in_first;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_swap;

  modport master (
    output in_nib, in_valid, in_first, out_ready,
    input  in_ready, out_data, out_valid, out_swap
  );
  modport slave (
    input  in_nib, in_valid, in_first, out_ready,
    output in_ready, out_data, out_valid, out_swap
  );
endinterface

// File: rtl/nibble_packer.sv
// nibble_packer: pairs a 4-bit nibble stream into bytes (high nibble first),
// buffers them in a DEPTH-entry FIFO and presents them to the nibble swapper.
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   bus      nibble_packer_if.slave (nibble in, byte out, out_swap strobe)
//   sync_err sticky framing-error flag, cleared by clr_err
//   byte_cnt saturating count of bytes written into the FIFO
//   clr_err  synchronous clear of sync_err, wins over a same-cycle set
module nibble_packer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  nibble_packer_if.slave   bus,
  output logic             sync_err,
  output logic [CNT_W-1:0] byte_cnt,
  input  logic             clr_err
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, HALF} state_t;

  state_t              state, state_nx;
  logic [3:0]          hi_q;
  logic [DEPTH-1:0][7:0] mem;
  logic [AW:0]         wr_ptr, rd_ptr;
  logic                full, empty, pop, accept;
  logic                latch_hi, push, err_set;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = ~empty & bus.out_ready;

  assign bus.out_valid = ~empty;
  assign bus.out_data  = mem[rd_ptr[AW-1:0]];
  assign bus.out_swap  = pop;

  // A high nibble never needs FIFO space; a low nibble may use the slot freed
  // by a same-cycle pop. Gated by reset so nothing is accepted while held.
  assign bus.in_ready = reset & ((state == IDLE) | ~full | pop);
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    state_nx = state;
    latch_hi = 1'b0;
    push     = 1'b0;
    err_set  = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          if (bus.in_first) begin
            latch_hi = 1'b1;
            state_nx = HALF;
          end else begin
            err_set = 1'b1;           // orphan low nibble is dropped
          end
        end
        HALF: begin
          if (bus.in_first) begin
            err_set  = 1'b1;          // restart byte with the new high nibble
            latch_hi = 1'b1;
          end else begin
            push     = 1'b1;
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      hi_q  <= '0;
    end else begin
      state <= state_nx;
      if (latch_hi) hi_q <= bus.in_nib;
    end
  end

  // Storage is cleared on reset so out_data reads 0 before the first push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= {hi_q, bus.in_nib};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt <= '0;
      sync_err <= 1'b0;
    end else begin
      if (push && (byte_cnt != {CNT_W{1'b1}})) byte_cnt <= byte_cnt + 1'b1;
      if (clr_err)      sync_err <= 1'b0;
      else if (err_set) sync_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_nibble_packer.sv
module tb_nibble_packer;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             clr_err = 1'b0;
  logic             sync_err;
  logic [CNT_W-1:0] byte_cnt;

  nibble_packer_if bus();

  nibble_packer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .sync_err(sync_err), .byte_cnt(byte_cnt), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every consumed byte must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      chk("out_swap", {31'd0, bus.out_swap}, 32'd1);
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_byte: got %0h expected none", bus.out_data);
      end else begin
        chk("out_data", {24'd0, bus.out_data}, {24'd0, sb_q.pop_front()});
      end
    end else if (bus.out_swap !== 1'b0) begin
      tests++;
      fails++;
      $display("FAIL out_swap_idle: got %b expected 0", bus.out_swap);
    end
  end

  // Starts and ends at posedge+#1.
  task automatic send(input logic [3:0] n, input logic first);
    int k;
    bus.in_nib   = n;
    bus.in_first = first;
    bus.in_valid = 1'b1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    if (k == 50) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stuck 0 for nibble %0h", n);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    sb_q.push_back(b);
    send(b[7:4], 1'b1);
    send(b[3:0], 1'b0);
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (sb_q.size() == 0 && !bus.out_valid) break;
    end
    chk("drain_empty", sb_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    bus.in_nib = '0; bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.out_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
    chk("rst_out_data", {24'd0, bus.out_data}, 0);
    chk("rst_sync_err", {31'd0, sync_err}, 0);
    chk("rst_byte_cnt", {28'd0, byte_cnt}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // Basic pack
    bus.out_ready = 1'b1;
    sb_q.push_back(8'hA5);
    send(4'hA, 1'b1);
    chk("basic_pre_valid", {31'd0, bus.out_valid}, 0);
    send(4'h5, 1'b0);
    chk("basic_valid", {31'd0, bus.out_valid}, 1);
    chk("basic_data", {24'd0, bus.out_data}, 32'hA5);
    chk("basic_cnt", {28'd0, byte_cnt}, 1);
    drain();

    // Backpressure, then push+pop on full
    bus.out_ready = 1'b0;
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    chk("full_hold_data", {24'd0, bus.out_data}, 32'h12);
    sb_q.push_back(8'h9A);
    send(4'h9, 1'b1);
    bus.in_nib = 4'hA; bus.in_first = 1'b0; bus.in_valid = 1'b1;
    @(negedge clk);
    chk("full_in_ready", {31'd0, bus.in_ready}, 0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("pass_in_ready", {31'd0, bus.in_ready}, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    sb_q.push_back(8'hBC);
    send(4'hB, 1'b1);
    bus.in_nib = 4'hC; bus.in_first = 1'b0; bus.in_valid = 1'b1;
    @(negedge clk);
    chk("still_full", {31'd0, bus.in_ready}, 0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    drain();
    chk("bp_cnt", {28'd0, byte_cnt}, 7);

    // Framing errors
    chk("err_clean", {31'd0, sync_err}, 0);
    sb_q.push_back(8'h7C);
    send(4'h3, 1'b1);
    send(4'h7, 1'b1);
    chk("err_double_first", {31'd0, sync_err}, 1);
    send(4'hC, 1'b0);
    drain();
    chk("err_cnt", {28'd0, byte_cnt}, 8);
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    chk("err_clr", {31'd0, sync_err}, 0);
    send(4'h4, 1'b0);
    chk("err_lone_low", {31'd0, sync_err}, 1);
    repeat (2) @(posedge clk); #1;
    chk("lone_dropped_cnt", {28'd0, byte_cnt}, 8);
    chk("lone_dropped_valid", {31'd0, bus.out_valid}, 0);
    clr_err = 1'b1;
    send(4'h4, 1'b0);
    clr_err = 1'b0;
    chk("clr_priority", {31'd0, sync_err}, 0);

    // Reset mid-HALF with two bytes queued
    bus.out_ready = 1'b0;
    send(4'h4, 1'b0);
    send_byte(8'hDE);
    send_byte(8'hAD);
    send(4'hF, 1'b1);
    chk("pre_rst_valid", {31'd0, bus.out_valid}, 1);
    chk("pre_rst_err", {31'd0, sync_err}, 1);
    reset = 1'b0;
    #1;
    sb_q.delete();
    chk("mid_rst_valid", {31'd0, bus.out_valid}, 0);
    chk("mid_rst_data", {24'd0, bus.out_data}, 0);
    chk("mid_rst_err", {31'd0, sync_err}, 0);
    chk("mid_rst_cnt", {28'd0, byte_cnt}, 0);
    chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    send(4'h5, 1'b0);
    chk("post_rst_idle_err", {31'd0, sync_err}, 1);
    repeat (2) @(posedge clk); #1;
    chk("post_rst_no_byte", {31'd0, bus.out_valid}, 0);
    chk("post_rst_cnt", {28'd0, byte_cnt}, 0);
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;

    // Saturation
    for (int i = 0; i < 20; i++) begin
      b = 8'(i * 17 + 3);
      send_byte(b);
      if (i == 9)  chk("cnt_10", {28'd0, byte_cnt}, 32'hA);
      if (i == 14) chk("cnt_15", {28'd0, byte_cnt}, 32'hF);
    end
    chk("cnt_sat", {28'd0, byte_cnt}, 32'hF);
    drain();
    chk("sat_no_err", {31'd0, sync_err}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
